// File: rtl/mips_boot_pkg.sv
// rtl/mips_boot_pkg.sv - shared states, sizes and per-state output decode for the imem boot loader
package mips_boot_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        WRITE,
        CSUM,
        RUN,
        ERROR
    } boot_state_t;

    typedef struct packed {
        logic rx_ready;
        logic cpu_rst;
        logic busy;
        logic done;
        logic err;
    } boot_flags_t;

    // Status outputs are a pure function of the state they are entering,
    // so the FSM registers them alongside the state itself.
    function automatic boot_flags_t state_flags(input boot_state_t s);
        boot_flags_t f;
        f.rx_ready = 1'b0;
        f.cpu_rst  = 1'b1;
        f.busy     = 1'b1;
        f.done     = 1'b0;
        f.err      = 1'b0;
        case (s)
            HDR0, HDR1, DATA, CSUM: f.rx_ready = 1'b1;
            RUN: begin
                f.cpu_rst = 1'b0;
                f.busy    = 1'b0;
                f.done    = 1'b1;
            end
            ERROR: begin
                f.busy = 1'b0;
                f.err  = 1'b1;
            end
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// rtl/boot_word_assembler.sv - little-endian byte-to-word shift register with modulo-4 byte counter
module boot_word_assembler
    import mips_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        shift_en,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] byte_cnt;

    // High while the byte completing the current word is being shifted in.
    assign word_full = shift_en && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

    // Bytes enter at the top so the first byte of a word settles in bits 7:0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (shift_en) begin
            word     <= {byte_in, word[31:8]};
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot sequencer loading instruction memory from a byte stream; BOOT_CHECKSUM_EN adds a trailing XOR check byte
module imem_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int HDR_W = HDR_BYTES * 8;

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t LOAD_END = CSUM;
`else
    localparam boot_state_t LOAD_END = RUN;
`endif

    boot_state_t      state;
    boot_state_t      state_nxt;
    boot_flags_t      flags;
    logic [HDR_W-1:0] word_cnt;
    logic [HDR_W-1:0] hdr_n;
    logic [ADDR_W:0]  index;
    logic             accept;
    logic             shift_en;
    logic             clear;
    logic             word_full;
    logic             last_word;
    logic             too_big;

    assign accept    = rx_valid && rx_ready;
    assign shift_en  = accept && (state == DATA);
    assign clear     = (state == RUN) && reload;
    assign hdr_n     = {rx_byte, word_cnt[7:0]};
    assign too_big   = 32'(hdr_n) > 32'(DEPTH);
    assign last_word = 32'(index) == (32'(word_cnt) - 32'd1);

    assign rx_ready   = flags.rx_ready;
    assign cpu_rst    = flags.cpu_rst;
    assign busy       = flags.busy;
    assign done       = flags.done;
    assign err        = flags.err;
    assign imem_waddr = index[ADDR_W-1:0];

    boot_word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .clear     (clear),
        .byte_in   (rx_byte),
        .word      (imem_wdata),
        .word_full (word_full)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR over every header and data byte of the current image.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            csum <= '0;
        end else if (accept && (state != CSUM)) begin
            csum <= csum ^ rx_byte;
        end
    end
`endif

    // Next-state selection; the header is judged as its high byte arrives.
    always_comb begin
        state_nxt = state;
        case (state)
            HDR0:  if (accept) state_nxt = HDR1;
            HDR1: begin
                if (accept) begin
                    if (too_big)           state_nxt = ERROR;
                    else if (hdr_n == '0)  state_nxt = LOAD_END;
                    else                   state_nxt = DATA;
                end
            end
            DATA:  if (word_full) state_nxt = WRITE;
            WRITE: state_nxt = last_word ? LOAD_END : DATA;
`ifdef BOOT_CHECKSUM_EN
            CSUM:  if (accept) state_nxt = (rx_byte == csum) ? RUN : ERROR;
`endif
            RUN:   if (reload) state_nxt = HDR0;
            ERROR: state_nxt = ERROR;
            default: state_nxt = HDR0;
        endcase
    end

    // State, registered status outputs, header count and write index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HDR0;
            flags    <= state_flags(HDR0);
            imem_we  <= 1'b0;
            word_cnt <= '0;
            index    <= '0;
        end else begin
            state   <= state_nxt;
            flags   <= state_flags(state_nxt);
            imem_we <= (state_nxt == WRITE);
            if (accept && (state == HDR0)) word_cnt[7:0]       <= rx_byte;
            if (accept && (state == HDR1)) word_cnt[HDR_W-1:8] <= rx_byte;
            if (clear) begin
                index <= '0;
            end else if (state == WRITE) begin
                index <= index + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        reload = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int          n_assert = 0;
    int          n_fail = 0;
    int          we_wide = 0;
    logic        we_prev = 1'b0;
    logic [7:0]  csum_acc = 8'h00;
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    always #5 clk = ~clk;

    imem_boot_loader dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_waddr);
            wr_data.push_back(imem_wdata);
            if (we_prev) we_wide++;
        end
        we_prev <= imem_we;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        reload = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_image();
        csum_acc = 8'h00;
        wr_addr.delete();
        wr_data.delete();
        we_wide = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int budget;
        if (rnd) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_byte = b;
        budget = 50;
        while (!rx_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL rx_ready_wait: observed rx_ready=0 expected 1 within 50 cycles");
        end else begin
            csum_acc = csum_acc ^ b;
        end
        @(negedge clk);
    endtask

    task automatic send_csum(input logic [7:0] corrupt);
`ifdef BOOT_CHECKSUM_EN
        send_byte(csum_acc ^ corrupt, 1'b0);
`else
        if (corrupt != 8'h00) rx_byte = corrupt;
`endif
    endtask

    task automatic wait_done(input string tag);
        int budget;
        budget = 100;
        while (!done && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(tag, done, 1);
    endtask

    task automatic check_write(input int i, input logic [7:0] a, input logic [31:0] d);
        if (wr_data.size() > i) begin
            chk($sformatf("wr%0d_addr", i), wr_addr[i], a);
            chk($sformatf("wr%0d_data", i), wr_data[i], d);
        end else begin
            chk($sformatf("wr%0d_present", i), 0, 1);
        end
    endtask

    initial begin
        // Test 1: two-word image with rx_valid held high
        do_reset();
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_waddr", imem_waddr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        start_image();
        send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h20, 1'b0); send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h05, 1'b0);
        chk("t1_w0_we", imem_we, 1);
        chk("t1_w0_addr", imem_waddr, 0);
        chk("t1_w0_data", imem_wdata, 32'h05000820);
        chk("t1_w0_rx_ready", rx_ready, 0);
        rx_byte = 8'h2B;
        @(negedge clk);
        chk("t1_ready_t2", rx_ready, 1);
        chk("t1_we_one_cycle", imem_we, 0);
        send_byte(8'h2B, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        chk("t1_w1_we", imem_we, 1);
        chk("t1_w1_addr", imem_waddr, 1);
        chk("t1_w1_data", imem_wdata, 32'h0000012B);
        chk("t1_w1_cpu_rst", cpu_rst, 1);
        rx_byte = 8'hFF;
`ifdef BOOT_CHECKSUM_EN
        send_csum(8'h00);
`else
        @(negedge clk);
`endif
        chk("t1_cpu_rst_fall", cpu_rst, 0);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_run_rx_ready", rx_ready, 0);
        rx_byte = 8'hFF;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        chk("t1_n_writes", wr_data.size(), 2);
        check_write(0, 8'h00, 32'h05000820);
        check_write(1, 8'h01, 32'h0000012B);
        chk("t1_we_width", we_wide, 0);
        chk("t1_still_done", done, 1);

        // Test 2: empty image goes straight to RUN
        do_reset();
        start_image();
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_csum(8'h00);
        chk("t2_cpu_rst", cpu_rst, 0);
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_no_writes", wr_data.size(), 0);

        // Test 3: oversize header is rejected and only rst recovers
        do_reset();
        start_image();
        send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0);
        chk("t3_err", err, 1);
        chk("t3_cpu_rst", cpu_rst, 1);
        chk("t3_busy", busy, 0);
        chk("t3_rx_ready", rx_ready, 0);
        rx_byte = 8'h55;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        chk("t3_err_after_reload", err, 1);
        chk("t3_cpu_rst_after_reload", cpu_rst, 1);
        chk("t3_done_after_reload", done, 0);
        chk("t3_rx_ready_after_reload", rx_ready, 0);
        chk("t3_no_writes", wr_data.size(), 0);
        do_reset();
        chk("t3_rst_err", err, 0);
        chk("t3_rst_rx_ready", rx_ready, 1);
        chk("t3_rst_busy", busy, 1);

        // Test 4: three words with rx_valid gaps
        start_image();
        send_byte(8'h03, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h08, 1'b1); send_byte(8'h8C, 1'b1);
        send_byte(8'h20, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h09, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h08, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1); send_byte(8'hAC, 1'b1);
        send_csum(8'h00);
        rx_valid = 1'b0;
        wait_done("t4_done");
        chk("t4_n_writes", wr_data.size(), 3);
        check_write(0, 8'h00, 32'h8C080004);
        check_write(1, 8'h01, 32'h01094020);
        check_write(2, 8'h02, 32'hAC0A0008);
        chk("t4_we_width", we_wide, 0);

        // Test 5: reset mid-load, then a fresh one-word image
        do_reset();
        start_image();
        send_byte(8'h04, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h06, 1'b0);
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_rx_ready", rx_ready, 1);
        chk("t5_rst_busy", busy, 1);
        chk("t5_rst_we", imem_we, 0);
        chk("t5_rst_waddr", imem_waddr, 0);
        chk("t5_partial_writes", wr_data.size(), 1);
        check_write(0, 8'h00, 32'h04030201);
        start_image();
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'hEF, 1'b0); send_byte(8'hBE, 1'b0); send_byte(8'hAD, 1'b0); send_byte(8'hDE, 1'b0);
        send_csum(8'h00);
        rx_valid = 1'b0;
        wait_done("t5_done");
        chk("t5_n_writes", wr_data.size(), 1);
        check_write(0, 8'h00, 32'hDEADBEEF);

        // Test 6: reload from RUN
        start_image();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("t6_reload_cpu_rst", cpu_rst, 1);
        chk("t6_reload_done", done, 0);
        chk("t6_reload_busy", busy, 1);
        chk("t6_reload_rx_ready", rx_ready, 1);
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        chk("t6_mid_cpu_rst", cpu_rst, 1);
        send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
        send_csum(8'h00);
        rx_valid = 1'b0;
        wait_done("t6_done");
        chk("t6_cpu_rst_released", cpu_rst, 0);
        chk("t6_n_writes", wr_data.size(), 1);
        check_write(0, 8'h00, 32'h44332211);
`ifdef BOOT_CHECKSUM_EN
        start_image();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
        chk("t6_csum_expected", csum_acc, 8'h45);
        send_csum(8'h03);
        rx_valid = 1'b0;
        chk("t6_bad_csum_err", err, 1);
        chk("t6_bad_csum_done", done, 0);
        chk("t6_bad_csum_cpu_rst", cpu_rst, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
